// File: rtl/rs_pkg.sv
// Shared GF(2^8) constants, the xtime helper and the syndrome sequencer state type
// for the Reed-Solomon decoder front end.
package rs_pkg;

    localparam int         SYM_W    = 8;
    localparam logic [8:0] GF_POLY  = 9'h11D;
    localparam logic [7:0] GF_ALPHA = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    // Multiply by alpha (0x02): shift left and fold the overflow bit back through the field polynomial.
    function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] x);
        return {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? GF_POLY[SYM_W-1:0] : '0);
    endfunction

endpackage

// File: rtl/rs_syndrome_seq_gf_mul.sv
// Combinational GF(2^8) multiplier over poly 0x11D (shift-and-add form).
module multiply
    import rs_pkg::*;
(
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    output logic [SYM_W-1:0] p
);

    logic [SYM_W-1:0] shifted;

    always_comb begin
        p       = '0;
        shifted = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) begin
                p = p ^ shifted;
            end
            shifted = gf_xtime(shifted);
        end
    end

endmodule

// File: rtl/rs_syndrome_seq.sv
// Horner-rule RS syndrome sequencer: one shared GF multiplier updates one syndrome per
// cycle per received symbol, then the finished syndromes are streamed out serially.
module rs_syndrome_seq
    import rs_pkg::*;
#(
    parameter  int NSYN = 16,
    localparam int IW   = $clog2(NSYN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_last,
    output logic             syn_valid,
    input  logic             syn_ready,
    output logic [SYM_W-1:0] syn_data,
    output logic [IW-1:0]    syn_idx,
    output logic             syn_last,
    output logic             cw_err
);

    state_t           state;
    logic [SYM_W-1:0] s [NSYN];
    logic [SYM_W-1:0] alpha_pow;
    logic [SYM_W-1:0] sym;
    logic [SYM_W-1:0] product;
    logic [SYM_W-1:0] s_new;
    logic [IW-1:0]    j;
    logic [IW-1:0]    next_idx;
    logic             last_seen;
    logic             any_nz;

    multiply gf_mul (
        .a (s[j]),
        .b (alpha_pow),
        .p (product)
    );

    // The last syndrome is still being written in the final ACC cycle, so use its new value.
    always_comb begin
        s_new    = product ^ sym;
        next_idx = syn_idx + 1'b1;
        any_nz   = (s_new != '0);
        for (int i = 0; i < NSYN - 1; i++) begin
            any_nz = any_nz | (s[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < NSYN; i++) begin
                s[i] <= '0;
            end
            alpha_pow <= 8'h01;
            sym       <= '0;
            j         <= '0;
            last_seen <= 1'b0;
            in_ready  <= 1'b1;
            syn_valid <= 1'b0;
            syn_data  <= '0;
            syn_idx   <= '0;
            syn_last  <= 1'b0;
            cw_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sym       <= in_data;
                        last_seen <= in_last;
                        j         <= '0;
                        alpha_pow <= 8'h01;
                        in_ready  <= 1'b0;
                        cw_err    <= 1'b0;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    s[j]      <= s_new;
                    alpha_pow <= gf_xtime(alpha_pow);
                    j         <= j + 1'b1;
                    if (j == IW'(NSYN - 1)) begin
                        if (last_seen) begin
                            state     <= OUT;
                            syn_valid <= 1'b1;
                            syn_data  <= s[0];
                            syn_idx   <= '0;
                            syn_last  <= 1'b0;
                            cw_err    <= any_nz;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (syn_ready) begin
                        if (syn_last) begin
                            for (int i = 0; i < NSYN; i++) begin
                                s[i] <= '0;
                            end
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            syn_valid <= 1'b0;
                            syn_data  <= '0;
                            syn_idx   <= '0;
                            syn_last  <= 1'b0;
                        end else begin
                            syn_idx  <= next_idx;
                            syn_data <= s[next_idx];
                            syn_last <= (next_idx == IW'(NSYN - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Directed self-checking bench for rs_syndrome_seq (NSYN = 16) with hand-computed syndromes.
module tb_rs_syndrome_seq;

    localparam int NSYN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       syn_valid;
    logic       syn_ready;
    logic [7:0] syn_data;
    logic [3:0] syn_idx;
    logic       syn_last;
    logic       cw_err;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_syn [NSYN];

    rs_syndrome_seq #(.NSYN(NSYN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .syn_valid (syn_valid),
        .syn_ready (syn_ready),
        .syn_data  (syn_data),
        .syn_idx   (syn_idx),
        .syn_last  (syn_last),
        .cw_err    (cw_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic last);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        checkOutput("accept_wait", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_in_ready"},  32'(in_ready),  32'h1);
        checkOutput({name, "_syn_valid"}, 32'(syn_valid), 32'h0);
        checkOutput({name, "_syn_data"},  32'(syn_data),  32'h0);
        checkOutput({name, "_syn_idx"},   32'(syn_idx),   32'h0);
        checkOutput({name, "_syn_last"},  32'(syn_last),  32'h0);
        checkOutput({name, "_cw_err"},    32'(cw_err),    32'h0);
    endtask

    task automatic collectSyndromes(input string name, input logic exp_err, input int stall_idx);
        int n = 0;
        syn_ready = 1'b1;
        while (!syn_valid && n < 200) begin
            tick();
            n++;
        end
        checkOutput({name, "_valid"},  32'(syn_valid), 32'h1);
        checkOutput({name, "_cw_err"}, 32'(cw_err),    32'(exp_err));
        for (int i = 0; i < NSYN; i++) begin
            if (i == stall_idx) begin
                syn_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    checkOutput({name, "_stall_data"}, 32'(syn_data), 32'(exp_syn[i]));
                    checkOutput({name, "_stall_idx"},  32'(syn_idx),  32'(i));
                end
                syn_ready = 1'b1;
            end
            checkOutput({name, "_data"}, 32'(syn_data), 32'(exp_syn[i]));
            checkOutput({name, "_idx"},  32'(syn_idx),  32'(i));
            checkOutput({name, "_last"}, 32'(syn_last), (i == NSYN - 1) ? 32'h1 : 32'h0);
            tick();
        end
        checkOutput({name, "_done"}, 32'(syn_valid), 32'h0);
        syn_ready = 1'b0;
    endtask

    initial begin
        int cycles;
        logic [7:0] alpha_tbl [NSYN] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                         8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        syn_ready = 1'b0;
        tick();
        tick();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        tick();
        checkResetOutputs("post_reset");

        // Five zero symbols: every syndrome is zero, no error flagged.
        for (int i = 0; i < NSYN; i++) exp_syn[i] = 8'h00;
        for (int i = 0; i < 5; i++) applyStimulus(8'h00, (i == 4));
        collectSyndromes("zeros", 1'b0, -1);

        // Single-symbol codeword: every syndrome equals r_0.
        for (int i = 0; i < NSYN; i++) exp_syn[i] = 8'h5A;
        applyStimulus(8'h5A, 1'b1);
        collectSyndromes("single", 1'b1, -1);
        tick();
        tick();
        checkOutput("cw_err_hold", 32'(cw_err), 32'h1);

        // 0x01 then 0x00 with in_valid held high: syndromes are alpha^j, stall at idx 4.
        for (int i = 0; i < NSYN; i++) exp_syn[i] = alpha_tbl[i];
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_last  = 1'b0;
        tick();
        checkOutput("stream_cw_err_clear", 32'(cw_err),   32'h0);
        checkOutput("stream_busy",         32'(in_ready), 32'h0);
        in_data = 8'h00;
        in_last = 1'b1;
        cycles  = 1;
        while (!in_ready && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput("ready_period", 32'(cycles), 32'd17);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("stream_busy2", 32'(in_ready), 32'h0);
        collectSyndromes("alpha", 1'b1, 4);

        // Reset midway through the second symbol's accumulation.
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        tick();
        tick();
        tick();
        tick();
        tick();
        checkOutput("mid_acc_busy", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checkResetOutputs("after_reset");
        for (int i = 0; i < NSYN; i++) exp_syn[i] = 8'h5A;
        applyStimulus(8'h5A, 1'b1);
        collectSyndromes("recover", 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
